stage2_pipe_ctrl: RTL and testbench

- Sequencing controller for the Stage 2 execute datapath of the 3-stage RV32 pipeline.
- Resolves branch and jump redirects from the Stage 2 comparator flags (BrLT/BrEq), and sequences load-use stalls.
- Sequences multi-cycle M-extension ops by start/done handshake with the MDU beside the ALU.
- Drives PC stall, Stage 1 flush, Stage 2 hold/bubble and PC select; does not touch forwarding selects.

---
 rtl/rv_pipe_pkg.sv | 33 +++
 rtl/stage2_pipe_ctrl_hazard_detect.sv | 73 +++++++
 rtl/stage2_pipe_ctrl.sv | 175 +++++++++++++++++
 tb/tb_stage2_pipe_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared RV32 pipeline constants and the Stage 2 controller state type.
package rv_pipe_pkg;

    localparam int unsigned INST_W    = 32;
    localparam int unsigned REG_IDX_W = 5;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0]        FUNCT7_MULDIV = 7'b0000001;
    localparam logic [INST_W-1:0] NOP_INST      = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_LD_STALL = 2'd2,
        ST_MDU_WAIT = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/stage2_pipe_ctrl_hazard_detect.sv
// Stage 1/Stage 2 decode: redirect, load-use and M-extension detection.
module hazard_detect
    import rv_pipe_pkg::*;
(
    input  logic [31:0] stage1_inst,
    input  logic [31:0] stage2_inst,
    input  logic        stage2_valid,
    input  logic        br_lt,
    input  logic        br_eq,
    output logic        load_use,
    output logic        is_mdu,
    output logic        taken
);

    logic [6:0]           s2_op;
    logic [2:0]           s2_f3;
    logic [6:0]           s2_f7;
    logic [REG_IDX_W-1:0] s2_rd;
    logic [6:0]           s1_op;
    logic [REG_IDX_W-1:0] s1_rs1;
    logic [REG_IDX_W-1:0] s1_rs2;
    logic                 s1_rs1_used;
    logic                 s1_rs2_used;
    logic                 br_cond;
    logic                 unused_bits;

    assign s2_op  = stage2_inst[6:0];
    assign s2_rd  = stage2_inst[11:7];
    assign s2_f3  = stage2_inst[14:12];
    assign s2_f7  = stage2_inst[31:25];
    assign s1_op  = stage1_inst[6:0];
    assign s1_rs1 = stage1_inst[19:15];
    assign s1_rs2 = stage1_inst[24:20];

    // Fields not needed for hazard decisions
    assign unused_bits = ^{stage2_inst[24:15], stage1_inst[31:25], stage1_inst[14:7]};

    // Branch outcome from comparator flags; reserved funct3 never taken
    always_comb begin
        br_cond = 1'b0;
        case (s2_f3)
            F3_BEQ:  br_cond = br_eq;
            F3_BNE:  br_cond = !br_eq;
            F3_BLT:  br_cond = br_lt;
            F3_BLTU: br_cond = br_lt;
            F3_BGE:  br_cond = !br_lt;
            F3_BGEU: br_cond = !br_lt;
            default: br_cond = 1'b0;
        endcase
    end

    // Which source registers the Stage 1 instruction actually reads
    always_comb begin
        s1_rs1_used = !((s1_op == OP_LUI) || (s1_op == OP_AUIPC) || (s1_op == OP_JAL));
        s1_rs2_used = (s1_op == OP_OP) || (s1_op == OP_STORE) || (s1_op == OP_BRANCH);
    end

    // Per-cycle decisions, all suppressed for a Stage 2 bubble
    always_comb begin
        taken    = 1'b0;
        load_use = 1'b0;
        is_mdu   = 1'b0;
        if (stage2_valid) begin
            taken    = (s2_op == OP_JAL) || (s2_op == OP_JALR) ||
                       ((s2_op == OP_BRANCH) && br_cond);
            load_use = (s2_op == OP_LOAD) && (s2_rd != '0) &&
                       ((s1_rs1_used && (s1_rs1 == s2_rd)) ||
                        (s1_rs2_used && (s1_rs2 == s2_rd)));
            is_mdu   = (s2_op == OP_OP) && (s2_f7 == FUNCT7_MULDIV);
        end
    end

endmodule

// File: rtl/stage2_pipe_ctrl.sv
// Stage 2 sequencing controller: redirects, load-use stalls, MDU handshake.
// Optional performance counters enabled by defining STAGE2_PIPE_CTRL_PERF_EN.
module stage2_pipe_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES      = 1,
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] stage1_inst,
    input  logic [31:0] stage2_inst,
    input  logic        stage2_valid,
    input  logic        br_lt,
    input  logic        br_eq,
    input  logic        mdu_done,
    output logic        pc_sel,
    output logic        pc_stall,
    output logic        stage1_flush,
    output logic        stage2_hold,
    output logic        stage2_bubble,
    output logic        mdu_start,
    output logic [1:0]  ctrl_state,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             is_mdu;
    logic             taken;

    hazard_detect u_hazard_detect (
        .stage1_inst  (stage1_inst),
        .stage2_inst  (stage2_inst),
        .stage2_valid (stage2_valid),
        .br_lt        (br_lt),
        .br_eq        (br_eq),
        .load_use     (load_use),
        .is_mdu       (is_mdu),
        .taken        (taken)
    );

    // State and down-counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; counter loaded on entry only and tested before decrement
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (taken) begin
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end else if (load_use) begin
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = ST_LD_STALL;
                        cnt_d   = STALL_LOAD;
                    end
                end else if (is_mdu) begin
                    state_d = ST_MDU_WAIT;
                end
            end
            ST_FLUSH, ST_LD_STALL: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_MDU_WAIT: begin
                if (mdu_done) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Mealy control outputs, forced quiet while reset is asserted
    always_comb begin
        pc_sel        = 1'b0;
        pc_stall      = 1'b0;
        stage1_flush  = 1'b0;
        stage2_hold   = 1'b0;
        stage2_bubble = 1'b0;
        mdu_start     = 1'b0;
        ctrl_state    = 2'(ST_RUN);
        if (rst_n) begin
            ctrl_state = 2'(state_q);
            case (state_q)
                ST_RUN: begin
                    if (taken) begin
                        pc_sel       = 1'b1;
                        stage1_flush = 1'b1;
                    end else if (load_use) begin
                        pc_stall      = 1'b1;
                        stage2_bubble = 1'b1;
                    end else if (is_mdu) begin
                        mdu_start   = 1'b1;
                        pc_stall    = 1'b1;
                        stage2_hold = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    stage1_flush = 1'b1;
                end
                ST_LD_STALL: begin
                    pc_stall      = 1'b1;
                    stage2_bubble = 1'b1;
                end
                ST_MDU_WAIT: begin
                    pc_stall    = !mdu_done;
                    stage2_hold = !mdu_done;
                end
                default: begin
                    ctrl_state = 2'(ST_RUN);
                end
            endcase
        end
    end

`ifdef STAGE2_PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic        redirect_entry;

    assign redirect_entry = rst_n && (state_q == ST_RUN) && taken;

    // Free-running stall and redirect counters
    always_comb begin
        perf_stall_d = perf_stall_q + 32'(pc_stall);
        perf_flush_d = perf_flush_q + 32'(redirect_entry);
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_stage2_pipe_ctrl.sv
// Scoreboard bench for stage2_pipe_ctrl: two instances with different
// flush/stall lengths share one randomized stimulus stream.
module tb_stage2_pipe_ctrl;

    localparam int FC_A = 1;
    localparam int LC_A = 1;
    localparam int FC_B = 3;
    localparam int LC_B = 2;
`ifdef STAGE2_PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] stage1_inst, stage2_inst;
    logic        stage2_valid, br_lt, br_eq, mdu_done;

    logic        psel_a, pstall_a, fl_a, hold_a, bub_a, start_a;
    logic        psel_b, pstall_b, fl_b, hold_b, bub_b, start_b;
    logic [1:0]  st_a, st_b;
    logic [31:0] pst_a, pfl_a, pst_b, pfl_b;

    always #5 clk = ~clk;

    stage2_pipe_ctrl #(.FLUSH_CYCLES(FC_A), .LOAD_STALL_CYCLES(LC_A), .CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .stage1_inst(stage1_inst), .stage2_inst(stage2_inst),
        .stage2_valid(stage2_valid), .br_lt(br_lt), .br_eq(br_eq), .mdu_done(mdu_done),
        .pc_sel(psel_a), .pc_stall(pstall_a), .stage1_flush(fl_a), .stage2_hold(hold_a),
        .stage2_bubble(bub_a), .mdu_start(start_a), .ctrl_state(st_a),
        .perf_stall_cnt(pst_a), .perf_flush_cnt(pfl_a)
    );

    stage2_pipe_ctrl #(.FLUSH_CYCLES(FC_B), .LOAD_STALL_CYCLES(LC_B), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .stage1_inst(stage1_inst), .stage2_inst(stage2_inst),
        .stage2_valid(stage2_valid), .br_lt(br_lt), .br_eq(br_eq), .mdu_done(mdu_done),
        .pc_sel(psel_b), .pc_stall(pstall_b), .stage1_flush(fl_b), .stage2_hold(hold_b),
        .stage2_bubble(bub_b), .mdu_start(start_b), .ctrl_state(st_b),
        .perf_stall_cnt(pst_b), .perf_flush_cnt(pfl_b)
    );

    // Expected per-cycle response for both instances
    typedef struct packed {
        logic [7:0]  ctl0;
        logic [31:0] pst0;
        logic [31:0] pfl0;
        logic [7:0]  ctl1;
        logic [31:0] pst1;
        logic [31:0] pfl1;
        logic        chk_perf;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: what the pipeline is doing, in remaining-cycle terms
    int          mode[2];     // 0 run, 1 flushing, 2 load stall, 3 waiting on MDU
    int          left[2];     // cycles still to go in flushing / load stall
    logic [31:0] m_pst[2];
    logic [31:0] m_pfl[2];

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic bit m_taken(input logic [31:0] i, input bit lt, input bit eq);
        logic [6:0] op;
        logic [2:0] f3;
        op = i[6:0];
        f3 = i[14:12];
        if (op == 7'h6F || op == 7'h67) return 1'b1;
        if (op != 7'h63) return 1'b0;
        case (f3)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic bit m_load_use(input logic [31:0] s2, input logic [31:0] s1);
        logic [6:0] op1;
        logic [4:0] rd;
        bit r1, r2;
        op1 = s1[6:0];
        rd  = s2[11:7];
        if (s2[6:0] != 7'h03 || rd == 5'd0) return 1'b0;
        r1 = !(op1 == 7'h37 || op1 == 7'h17 || op1 == 7'h6F);
        r2 = (op1 == 7'h33 || op1 == 7'h23 || op1 == 7'h63);
        return (r1 && s1[19:15] == rd) || (r2 && s1[24:20] == rd);
    endfunction

    function automatic bit m_mdu(input logic [31:0] s2);
        return s2[6:0] == 7'h33 && s2[31:25] == 7'd1;
    endfunction

    task automatic model_step(input int k, input int fc, input int lc, input bit rst,
                              input logic [31:0] s1, input logic [31:0] s2, input bit v,
                              input bit lt, input bit eq, input bit done,
                              output logic [7:0] ctl, output logic [31:0] pst,
                              output logic [31:0] pfl);
        bit psel, stall, fl, hold, bub, start;
        logic [1:0] st;
        psel = 0; stall = 0; fl = 0; hold = 0; bub = 0; start = 0;
        st  = 2'(mode[k]);
        pst = PERF ? m_pst[k] : 32'd0;
        pfl = PERF ? m_pfl[k] : 32'd0;
        if (!rst) begin
            st = 2'd0;
            mode[k] = 0; left[k] = 0; m_pst[k] = 0; m_pfl[k] = 0;
        end else begin
            case (mode[k])
                0: begin
                    if (v && m_taken(s2, lt, eq)) begin
                        psel = 1; fl = 1; m_pfl[k] = m_pfl[k] + 1;
                        if (fc > 1) begin mode[k] = 1; left[k] = fc - 1; end
                    end else if (v && m_load_use(s2, s1)) begin
                        stall = 1; bub = 1;
                        if (lc > 1) begin mode[k] = 2; left[k] = lc - 1; end
                    end else if (v && m_mdu(s2)) begin
                        start = 1; stall = 1; hold = 1; mode[k] = 3;
                    end
                end
                1: begin
                    fl = 1; left[k] = left[k] - 1;
                    if (left[k] == 0) mode[k] = 0;
                end
                2: begin
                    stall = 1; bub = 1; left[k] = left[k] - 1;
                    if (left[k] == 0) mode[k] = 0;
                end
                default: begin
                    if (done) mode[k] = 0;
                    else begin stall = 1; hold = 1; end
                end
            endcase
            if (stall) m_pst[k] = m_pst[k] + 1;
        end
        ctl = {psel, stall, fl, hold, bub, start, st};
    endtask

    // Apply one cycle of inputs, record expected outputs, advance one clock
    task automatic drive(input bit rst, input logic [31:0] s1, input logic [31:0] s2,
                         input bit v, input bit lt, input bit eq, input bit done);
        exp_t e;
        logic [7:0]  c0, c1;
        logic [31:0] ps0, pf0, ps1, pf1;
        rst_n = rst; stage1_inst = s1; stage2_inst = s2;
        stage2_valid = v; br_lt = lt; br_eq = eq; mdu_done = done;
        model_step(0, FC_A, LC_A, rst, s1, s2, v, lt, eq, done, c0, ps0, pf0);
        model_step(1, FC_B, LC_B, rst, s1, s2, v, lt, eq, done, c1, ps1, pf1);
        e.ctl0 = c0; e.pst0 = ps0; e.pfl0 = pf0;
        e.ctl1 = c1; e.pst1 = ps1; e.pfl1 = pf1;
        e.chk_perf = rst;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0] a, b, d;
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        d = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 10))
            0:  return enc(7'd0, 5'd0, a, 3'd2, d, 7'h03);
            1:  return enc(7'd0, b, a, 3'd0, d, 7'h33);
            2:  return enc(7'd1, b, a, 3'($urandom_range(0, 7)), d, 7'h33);
            3:  return enc(7'd0, b, a, 3'($urandom_range(0, 7)), 5'd0, 7'h63);
            4:  return enc(7'd0, b, a, 3'd0, d, 7'h6F);
            5:  return enc(7'd0, 5'd0, a, 3'd0, d, 7'h67);
            6:  return enc(7'd0, b, a, 3'd0, d, 7'h37);
            7:  return enc(7'd0, b, a, 3'd0, d, 7'h17);
            8:  return enc(7'd0, b, a, 3'd2, 5'd0, 7'h23);
            9:  return enc(7'd0, b, a, 3'd0, d, 7'h13);
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_ctl(input string sfx, input logic [7:0] act, input logic [7:0] exp);
        string nm[6];
        nm = '{"pc_sel", "pc_stall", "stage1_flush", "stage2_hold", "stage2_bubble", "mdu_start"};
        for (int i = 0; i < 6; i++) chk({nm[i], sfx}, 32'(act[7-i]), 32'(exp[7-i]));
        chk({"ctrl_state", sfx}, 32'(act[1:0]), 32'(exp[1:0]));
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk_ctl("_a", {psel_a, pstall_a, fl_a, hold_a, bub_a, start_a, st_a}, e.ctl0);
                chk_ctl("_b", {psel_b, pstall_b, fl_b, hold_b, bub_b, start_b, st_b}, e.ctl1);
                if (e.chk_perf) begin
                    chk("perf_stall_cnt_a", pst_a, e.pst0);
                    chk("perf_flush_cnt_a", pfl_a, e.pfl0);
                    chk("perf_stall_cnt_b", pst_b, e.pst1);
                    chk("perf_flush_cnt_b", pfl_b, e.pfl1);
                end
            end
        end
    end

    // Stimulus: directed scenarios first, then randomized traffic
    initial begin
        logic [31:0] beq, jalr, lw5, lw0, add_dep, add_x0, lui5, mul;
        for (int k = 0; k < 2; k++) begin
            mode[k] = 0; left[k] = 0; m_pst[k] = 0; m_pfl[k] = 0;
        end
        rst_n = 1'b0; stage1_inst = NOP; stage2_inst = NOP;
        stage2_valid = 1'b0; br_lt = 1'b0; br_eq = 1'b0; mdu_done = 1'b0;
        beq     = enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd0, 7'h63);
        jalr    = enc(7'd0, 5'd0, 5'd1, 3'd0, 5'd1, 7'h67);
        lw5     = enc(7'd0, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03);
        lw0     = enc(7'd0, 5'd0, 5'd1, 3'd2, 5'd0, 7'h03);
        add_dep = enc(7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'h33);
        add_x0  = enc(7'd0, 5'd0, 5'd0, 3'd0, 5'd6, 7'h33);
        lui5    = enc(7'd0, 5'd5, 5'd5, 3'd0, 5'd5, 7'h37);
        mul     = enc(7'd1, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);
        @(posedge clk);
        #1;
        repeat (2) drive(0, NOP, NOP, 0, 0, 0, 0);

        drive(1, NOP, beq, 1, 0, 1, 0);                 // taken BEQ
        repeat (3) drive(1, NOP, NOP, 1, 0, 0, 0);
        drive(1, NOP, beq, 1, 0, 0, 0);                 // not taken
        drive(1, NOP, jalr, 1, 0, 0, 0);                // JALR
        repeat (3) drive(1, NOP, NOP, 1, 0, 0, 0);
        drive(1, add_dep, lw5, 1, 0, 0, 0);             // load-use
        repeat (2) drive(1, NOP, NOP, 1, 0, 0, 0);
        drive(1, add_x0, lw0, 1, 0, 0, 0);              // LW x0
        drive(1, lui5, lw5, 1, 0, 0, 0);                // dependent LUI
        drive(1, add_dep, lw5, 0, 0, 0, 0);             // bubble in Stage 2
        drive(1, NOP, NOP, 1, 0, 0, 1);                 // spurious done
        repeat (4) drive(1, NOP, mul, 1, 0, 0, 0);      // MUL, done 4 cycles later
        drive(1, NOP, mul, 1, 0, 0, 1);
        drive(1, NOP, NOP, 1, 0, 0, 0);
        drive(1, NOP, mul, 1, 0, 0, 0);                 // reset during MDU wait
        drive(1, NOP, mul, 1, 0, 0, 0);
        drive(0, NOP, mul, 1, 0, 0, 0);
        repeat (2) drive(1, NOP, mul, 0, 0, 0, 0);

        for (int n = 0; n < 2000; n++) begin
            drive(($urandom_range(0, 199) != 0), rand_inst(), rand_inst(),
                  ($urandom_range(0, 99) < 85), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
